// File: rtl/alu_pkg.sv
// alu_pkg: ALU select codes, R-type funct codes, FSM state and MDU op types for alu_mdu_dec.
package alu_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} mdu_op_t;
endpackage

// File: rtl/mdu_core.sv
// mdu_core: iterative shift-add multiplier / restoring divider on magnitudes, one radix-2 step per cycle (divider only with ALU_MDU_DIV_EN).
module mdu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic               sgn, neg_q;
    logic [WIDTH-1:0]   ma, mb, m, q, q_n;
    logic [WIDTH:0]     acc, acc_n, sum;
    logic [2*WIDTH-1:0] prod, prod_s;
    assign sgn    = op == OP_MULT || op == OP_DIV;
    assign ma     = sgn && a[WIDTH-1] ? -a : a;
    assign mb     = sgn && b[WIDTH-1] ? -b : b;
    assign sum    = acc + (q[0] ? {1'b0, m} : '0);
    // results are taken from the post-step values so the final step and the HI/LO write share one edge
    assign prod   = {acc_n[WIDTH-1:0], q_n};
    assign prod_s = neg_q ? -prod : prod;
`ifdef ALU_MDU_DIV_EN
    logic             div, neg_r, dz;
    logic [WIDTH-1:0] a_q, quo, rem;
    logic [WIDTH:0]   sh, diff;
    mdu_op_t          op_q;
    assign div    = op_q == OP_DIV || op_q == OP_DIVU;
    assign sh     = {acc[WIDTH-1:0], q[WIDTH-1]};
    assign diff   = sh - {1'b0, m};
    assign acc_n  = div ? (diff[WIDTH] ? sh : diff) : {1'b0, sum[WIDTH:1]};
    assign q_n    = div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
    assign quo    = neg_q ? -q_n : q_n;
    assign rem    = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
    assign res_hi = div ? (dz ? a_q : rem) : prod_s[2*WIDTH-1:WIDTH];
    assign res_lo = div ? (dz ? '1 : quo) : prod_s[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (load) begin
            op_q  <= op;
            neg_r <= sgn && a[WIDTH-1];
            dz    <= b == '0;
            a_q   <= a;
        end
    end
`else
    assign acc_n  = {1'b0, sum[WIDTH:1]};
    assign q_n    = {sum[0], q[WIDTH-1:1]};
    assign res_hi = prod_s[2*WIDTH-1:WIDTH];
    assign res_lo = prod_s[WIDTH-1:0];
`endif
    always_ff @(posedge clk) begin
        if (load) begin
            acc   <= '0;
            q     <= ma;
            m     <= mb;
            neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc   <= acc_n;
            q     <= q_n;
        end
    end
endmodule

// File: rtl/alu_mdu_dec.sv
// alu_mdu_dec: ALU control decode plus iterative MUL/DIV unit with HI/LO; define ALU_MDU_DIV_EN to enable div/divu.
module alu_mdu_dec
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [WIDTH-1:0]  srca,
    input  logic [WIDTH-1:0]  srcb,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              illegal,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);
    localparam int CW = $clog2(WIDTH);
    logic [3:0]       ctl;
    logic             is_mop, is_mv, load, step;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] res_hi, res_lo;
    mdu_op_t          op_sel;
    state_t           state_q, state_d;
    always_comb begin
        ctl    = ALU_AND;
        illegal = 1'b0;
        is_mop = 1'b0;
        is_mv  = 1'b0;
        op_sel = OP_MULT;
        case (aluop)
            2'b00: ctl = ALU_ADD;
            2'b01: ctl = ALU_SUB;
            2'b11: ctl = ALU_OR;
            default: case (funct)
                F_ADD:   ctl = ALU_ADD;
                F_SUB:   ctl = ALU_SUB;
                F_AND:   ctl = ALU_AND;
                F_OR:    ctl = ALU_OR;
                F_XOR:   ctl = ALU_XOR;
                F_NOR:   ctl = ALU_NOR;
                F_SLT:   ctl = ALU_SLT;
                F_SLTU:  ctl = ALU_SLTU;
                F_SLL:   ctl = ALU_SLL;
                F_SRL:   ctl = ALU_SRL;
                F_MULT:  is_mop = 1'b1;
                F_MULTU: begin is_mop = 1'b1; op_sel = OP_MULTU; end
`ifdef ALU_MDU_DIV_EN
                F_DIV:   begin is_mop = 1'b1; op_sel = OP_DIV; end
                F_DIVU:  begin is_mop = 1'b1; op_sel = OP_DIVU; end
`endif
                F_MFHI, F_MFLO: is_mv = 1'b1;
                default: illegal = 1'b1;
            endcase
        endcase
    end
    assign alucontrol = CTRL_W'(ctl);
    assign busy  = state_q == S_RUN;
    assign done  = state_q == S_DONE;
    assign stall = busy && start && (is_mop || is_mv);
    always_comb begin
        load    = start && is_mop && state_q != S_RUN;
        step    = state_q == S_RUN;
        state_d = load ? S_RUN : step ? (cnt_q == '0 ? S_DONE : S_RUN) : S_IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= load ? CW'(WIDTH - 1) : step ? cnt_q - 1'b1 : cnt_q;
            if (step && cnt_q == '0) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end
    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .load   (load),
        .step   (step),
        .op     (op_sel),
        .a      (srca),
        .b      (srcb),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );
endmodule

// File: tb/tb_alu_mdu_dec.sv
// tb_alu_mdu_dec: randomized self-checking bench for alu_mdu_dec against an arithmetic reference model.
module tb_alu_mdu_dec;
    localparam int W = 32;
`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [5:0]   funct = 6'b0;
    logic [W-1:0] srca = '0, srcb = '0;
    logic [3:0]   alucontrol;
    logic         illegal, busy, stall, done;
    logic [W-1:0] hi, lo;
    int checks = 0, errors = 0;
    logic [5:0] pool [16] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                              6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b011000, 6'b011001,
                              6'b011010, 6'b011011, 6'b010000, 6'b010010};

    alu_mdu_dec #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop), .funct(funct),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .illegal(illegal),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dec_ref(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 5'b0_0010;
        if (op == 2'b01) return 5'b0_0110;
        if (op == 2'b11) return 5'b0_0001;
        case (f)
            6'b100000: return 5'b0_0010;
            6'b100010: return 5'b0_0110;
            6'b100100: return 5'b0_0000;
            6'b100101: return 5'b0_0001;
            6'b100110: return 5'b0_0011;
            6'b100111: return 5'b0_1100;
            6'b101010: return 5'b0_0111;
            6'b101011: return 5'b0_0101;
            6'b000000: return 5'b0_1000;
            6'b000010: return 5'b0_1001;
            6'b011000, 6'b011001, 6'b010000, 6'b010010: return 5'b0_0000;
            6'b011010, 6'b011011: return {!DIV_EN, 4'b0000};
            default: return 5'b1_0000;
        endcase
    endfunction

    // returns {hi, lo}
    function automatic logic [2*W-1:0] mdu_ref(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (f)
            6'b011000: return 64'(sa * sb);
            6'b011001: return 64'(ua * ub);
            6'b011010: return b == '0 ? {a, {W{1'b1}}} : {W'(sa % sb), W'(sa / sb)};
            default:   return b == '0 ? {a, {W{1'b1}}} : {W'(ua % ub), W'(ua / ub)};
        endcase
    endfunction

    // call at a falling edge; returns at the falling edge of the cycle where done is seen
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        start = 1'b1; aluop = 2'b10; funct = f; srca = a; srcb = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [2*W-1:0] e;
        int lat;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, stall} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, stall}); end
        checks++; if ({hi, lo} !== '0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
        reset = 1'b0;
        do_op(6'b011000, 32'd6, 32'd9, lat);
        e = mdu_ref(6'b011000, 32'd6, 32'd9);
        checks++; if (lat != W + 1) begin errors++; $display("FAIL first_start_latency got %0d want %0d", lat, W + 1); end
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL first_start_result got %h want %h", {hi, lo}, e); end
    endtask

    task automatic test_decode();
        logic [4:0] e;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            aluop = i < 2 ? 2'b10 : 2'($urandom_range(0, 3));
            funct = i == 0 ? 6'b100111 : i == 1 ? 6'b111111 : $urandom_range(0, 1) ? pool[$urandom_range(0, 15)] : 6'($urandom);
            #1;
            e = dec_ref(aluop, funct);
            checks++; if ({illegal, alucontrol} !== e) begin errors++; $display("FAIL decode op=%b f=%b got %b want %b", aluop, funct, {illegal, alucontrol}, e); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %b want 0", stall); end
        end
    endtask

    task automatic test_mult();
        logic [5:0] f;
        logic [W-1:0] a, b;
        logic [2*W-1:0] e;
        int lat;
        for (int i = 0; i < 7; i++) begin
            f = (i % 2 == 0 || i == 1) ? 6'b011000 : 6'b011001;
            a = i == 0 ? -32'sd3 : i == 1 ? 32'h8000_0000 : i == 2 ? 32'hFFFF_FFFF : $urandom;
            b = i == 0 ? 32'd7   : i == 1 ? 32'h8000_0000 : i == 2 ? 32'hFFFF_FFFF : $urandom;
            @(negedge clk);
            do_op(f, a, b, lat);
            e = mdu_ref(f, a, b);
            checks++; if (lat != W + 1) begin errors++; $display("FAIL mult_latency got %0d want %0d", lat, W + 1); end
            checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL mult f=%b a=%h b=%h got %h want %h", f, a, b, {hi, lo}, e); end
        end
        checks++; if ({hi, lo} === '0) begin errors++; $display("FAIL mult_nonzero got %h want nonzero", {hi, lo}); end
    endtask

`ifdef ALU_MDU_DIV_EN
    task automatic test_div();
        logic [5:0] f;
        logic [W-1:0] a, b;
        logic [2*W-1:0] e;
        int lat;
        for (int i = 0; i < 10; i++) begin
            f = (i == 0 || i % 2 == 1) ? 6'b011011 : 6'b011010;
            case (i)
                0: begin a = 32'd100; b = 32'd7; end
                2: begin a = -32'sd7; b = 32'd2; end
                4: begin a = 32'd5; b = 32'd0; end
                6: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: begin a = $urandom; b = $urandom_range(0, 1) ? 32'($urandom_range(1, 300)) : $urandom; end
            endcase
            @(negedge clk);
            do_op(f, a, b, lat);
            e = mdu_ref(f, a, b);
            checks++; if (lat != W + 1) begin errors++; $display("FAIL div_latency got %0d want %0d", lat, W + 1); end
            checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL div f=%b a=%h b=%h got %h want %h", f, a, b, {hi, lo}, e); end
        end
    endtask
`else
    task automatic test_div_off();
        logic [2*W-1:0] keep;
        keep = {hi, lo};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b1; aluop = 2'b10; funct = i == 0 ? 6'b011010 : 6'b011011; srca = 32'd5; srcb = 32'd0;
            #1;
            checks++; if ({illegal, alucontrol} !== 5'b1_0000) begin errors++; $display("FAIL div_off_decode got %b want 10000", {illegal, alucontrol}); end
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                start = 1'b0;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL div_off_busy got %b want 0", busy); end
            end
            checks++; if ({hi, lo} !== keep) begin errors++; $display("FAIL div_off_hilo got %h want %h", {hi, lo}, keep); end
        end
    endtask
`endif

    task automatic test_stall();
        logic [W-1:0] a, b;
        logic [2*W-1:0] e;
        logic exp_stall;
        a = $urandom; b = $urandom;
        e = mdu_ref(6'b011000, a, b);
        @(negedge clk);
        start = 1'b1; aluop = 2'b10; funct = 6'b011000; srca = a; srcb = b;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= W + 1; c++) begin
            if (c > 1) @(negedge clk);
            start = c >= 10;
            funct = (c >= 21 && c <= 25) ? 6'b100000 : (c >= 26 && c <= W) ? 6'b011001 : 6'b010000;
            srca = c >= 26 ? ~a : a;
            #1;
            exp_stall = c >= 10 && c <= W && (c < 21 || c > 25);
            checks++; if (stall !== exp_stall) begin errors++; $display("FAIL stall cycle %0d got %b want %b", c, stall, exp_stall); end
            checks++; if (done !== (c == W + 1)) begin errors++; $display("FAIL stall_done cycle %0d got %b want %b", c, done, c == W + 1); end
            if (c >= 21 && c <= 25) begin
                checks++; if (alucontrol !== 4'b0010) begin errors++; $display("FAIL stall_add_ctl got %b want 0010", alucontrol); end
            end
        end
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_no_restart busy got %b want 0", busy); end
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL stall_result got %h want %h", {hi, lo}, e); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] a, b;
        logic [2*W-1:0] e;
        int lat;
        @(negedge clk);
        start = 1'b1; aluop = 2'b10; funct = 6'b011001; srca = $urandom; srcb = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrun_reset_flags got %b want 00", {busy, done}); end
        checks++; if ({hi, lo} !== '0) begin errors++; $display("FAIL midrun_reset_hilo got %h want 0", {hi, lo}); end
        @(negedge clk);
        reset = 1'b0;
        a = $urandom; b = $urandom;
        do_op(6'b011000, a, b, lat);
        e = mdu_ref(6'b011000, a, b);
        checks++; if (lat != W + 1) begin errors++; $display("FAIL post_reset_latency got %0d want %0d", lat, W + 1); end
        checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL post_reset_result got %h want %h", {hi, lo}, e); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        logic [2*W-1:0] e;
        logic [5:0] f;
        int lat;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            f = i == 1 ? 6'b011001 : 6'b011000;
            a = $urandom; b = $urandom;
            do_op(f, a, b, lat);
            e = mdu_ref(f, a, b);
            checks++; if (lat != W + 1) begin errors++; $display("FAIL b2b_latency %0d got %0d want %0d", i, lat, W + 1); end
            checks++; if ({hi, lo} !== e) begin errors++; $display("FAIL b2b_result %0d got %h want %h", i, {hi, lo}, e); end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult();
`ifdef ALU_MDU_DIV_EN
        test_div();
`else
        test_div_off();
`endif
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
